// File: rtl/github_username_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : github_username_top                                            |
// | Brief   : Prescaled seven-segment digit counter on a shared 8-bit I/O    |
// |           slot. Define HEX_MODE_EN for a 0..F count instead of 0..9.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module github_username_top #(
  parameter int PRESCALE = 1000
) (
  input  logic [7:0] io_i,
  output logic [7:0] io_o
);

`ifdef HEX_MODE_EN
  localparam logic [3:0] c_DIGIT_MAX = 4'hF;
`else
  localparam logic [3:0] c_DIGIT_MAX = 4'd9;
`endif
  localparam logic [15:0] c_PRESC_LAST = 16'(PRESCALE - 1);

  logic        clk;
  logic        rst;
  logic        w_hold;
  logic        w_step;
  logic        w_wrap;
  logic        w_unused;
  logic [15:0] r_presc;
  logic [3:0]  r_digit;
  logic        r_wrap_flag;
  logic [6:0]  w_seg;

  assign clk      = io_i[0];
  assign rst      = io_i[1];
  assign w_hold   = io_i[2];
  assign w_unused = ^io_i[7:3];

  // Hold gates the step too, so a held terminal count does not keep stepping.
  assign w_step = !w_hold && (r_presc == c_PRESC_LAST);
  assign w_wrap = w_step && (r_digit == c_DIGIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 16'd0;
    end else if (!w_hold) begin
      r_presc <= w_step ? 16'd0 : r_presc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit     <= 4'd0;
      r_wrap_flag <= 1'b0;
    end else if (w_step) begin
      r_digit <= w_wrap ? 4'd0 : r_digit + 4'd1;
      if (w_wrap) begin
        r_wrap_flag <= ~r_wrap_flag;
      end
    end
  end

  always_comb begin
    w_seg = 7'h00;
    case (r_digit)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
`ifdef HEX_MODE_EN
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
`endif
      default: w_seg = 7'h00;
    endcase
  end

  assign io_o = {r_wrap_flag, w_seg};

endmodule
`default_nettype wire

// File: tb/tb_github_username_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_github_username_top                                         |
// | Brief   : Directed plus randomized bench for github_username_top with    |
// |           a step-count reference model (PRESCALE 1 and 3 instances).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_github_username_top;

`ifdef HEX_MODE_EN
  localparam int c_MOD = 16;
`else
  localparam int c_MOD = 10;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       hold = 1'b0;
  logic [4:0] junk = 5'd0;
  logic [7:0] io_i;
  logic [7:0] io_o1;
  logic [7:0] io_o3;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  assign io_i = {junk, hold, rst, clk};

  github_username_top #(.PRESCALE(1)) u_dut1 (.io_i(io_i), .io_o(io_o1));
  github_username_top #(.PRESCALE(3)) u_dut3 (.io_i(io_i), .io_o(io_o3));

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [0:15];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[d];
  endfunction

  // Output after a given number of digit steps since reset.
  function automatic logic [7:0] model(input int steps);
    logic flag;
    flag = 1'((steps / c_MOD) % 2);
    return {flag, glyph(steps % c_MOD)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_p1"}, io_o1, model(edges));
    check({tag, "_p3"}, io_o3, model(edges / 3));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step_edge(input string tag);
    @(posedge clk);
    if (!rst && !hold) edges++;
    @(negedge clk);
    check_both(tag);
  endtask

  // Asynchronous reset pulse entirely between two rising edges.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1 edges = 0;
    check_both(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #1;
    edges = 0;
    check("reset_p1", io_o1, 8'h3F);
    check("reset_p3", io_o3, 8'h3F);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step_edge("reset_held");
    rst = 1'b0;

    step_edge("first_edge");
    check("first_edge_const", io_o1, 8'h06);
    for (int i = 0; i < 3; i++) step_edge("count_up");
    check("digit4_const", io_o1, 8'h66);

    reset_pulse("reset2");
    for (int i = 0; i < 20; i++) begin
      step_edge("wrap_run");
      if (i == 9)  check("ten_edges",    io_o1, model(10));
      if (i == 19) check("twenty_edges", io_o1, model(20));
    end
`ifdef HEX_MODE_EN
    reset_pulse("reset_hex");
    for (int i = 0; i < 16; i++) begin
      step_edge("hex_run");
      if (i == 9)  check("hex_A", io_o1, 8'h77);
      if (i == 14) check("hex_F", io_o1, 8'h71);
      if (i == 15) check("hex_wrap", io_o1, 8'hBF);
    end
`else
    check("dec_twenty_const", io_o1, 8'h3F);
`endif

    reset_pulse("reset3");
    for (int i = 0; i < 3; i++) step_edge("to_digit3");
    hold = 1'b1;
    for (int i = 0; i < 5; i++) step_edge("held");
    check("held_const", io_o1, 8'h4F);
    hold = 1'b0;
    step_edge("release");
    check("release_const", io_o1, 8'h66);
    for (int i = 0; i < 3; i++) step_edge("to_digit7");
    reset_pulse("async_mid");
    check("async_const", io_o1, 8'h3F);
    step_edge("after_async");

    for (int i = 0; i < 400; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      junk = 5'($urandom);
      if ($urandom_range(0, 49) == 0) reset_pulse("rand_reset");
      step_edge("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
